// File: rtl/retire_writeback_pkg.sv
// Shared retire-stage types: ROB entry layout, store opcode, store queue entry.
package my_package;

    localparam int PREG_W = 6;
    localparam int XLEN   = 32;
    localparam int MEM_AW = 6;

    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic [6:0]        rd_opcode;
        logic [PREG_W-1:0] curr_d_reg;
        logic [PREG_W-1:0] old_d_reg;
        logic [XLEN-1:0]   rd_value;
        logic [XLEN-1:0]   rs1_value;
    } rob_entry;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } sq_entry;

endpackage

// File: rtl/retire_writeback_if.sv
// ROB-to-retire handshake bundle; lane 0 carries the oldest entry.
interface retire_if #(
    parameter int WIDTH = 2
);
    import my_package::*;

    logic [WIDTH-1:0] valid;
    rob_entry [WIDTH-1:0] entry;
    logic ready;

    modport master (output valid, output entry, input ready);
    modport slave  (input valid, input entry, output ready);

endinterface

// File: rtl/retire_writeback_store_queue.sv
// In-order store FIFO: up to WIDTH pushes per cycle, one pop per cycle.
module store_queue
    import my_package::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         push,
    input  sq_entry [WIDTH-1:0]      push_data,
    input  logic                     pop,
    output sq_entry                  head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sq_entry q [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] npush;
    logic [PW-1:0] slot [WIDTH];
    logic pop_eff;

    // Pushing lanes are packed into consecutive slots in lane order.
    always_comb begin
        npush = '0;
        for (int k = 0; k < WIDTH; k++) begin
            slot[k] = npush[PW-1:0];
            if (push[k]) npush = npush + CW'(1);
        end
    end

    assign empty   = (count == '0);
    assign pop_eff = pop && !empty;
    assign head    = q[rp];

    always_ff @(posedge clk) begin
        for (int k = 0; k < WIDTH; k++) begin
            if (push[k]) q[wp + slot[k]] <= push_data[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + npush[PW-1:0];
            rp    <= rp + PW'(pop_eff);
            count <= count + npush - CW'(pop_eff);
        end
    end

endmodule

// File: rtl/retire_writeback.sv
// Retire/writeback stage: commits ROB results to the register file and
// routes stores through an in-order queue that drains into data memory.
module retire_writeback
    import my_package::*;
#(
    parameter int RETIRE_WIDTH = 2,
    parameter int NUM_PREGS    = 64,
    parameter int MEM_DEPTH    = 64,
    parameter int SQ_DEPTH     = 8,
    parameter int DATA_W       = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    retire_if.slave                             ret,
    output logic [NUM_PREGS-1:0]                free_regs,
    output logic [NUM_PREGS-1:0]                reg_ready_o,
    output logic [NUM_PREGS-1:0][DATA_W-1:0]    register_file,
    output logic [MEM_DEPTH-1:0][DATA_W-1:0]    memory,
    output logic [$clog2(SQ_DEPTH):0]           sq_count,
    output logic                                sq_empty,
    output logic [31:0]                         retired_count
);
    logic [RETIRE_WIDTH-1:0] lane_acc;
    logic [RETIRE_WIDTH-1:0] is_store;
    logic [RETIRE_WIDTH-1:0] push;
    sq_entry [RETIRE_WIDTH-1:0] push_data;
    sq_entry head;
    logic [NUM_PREGS-1:0] nxt_free;
    logic [NUM_PREGS-1:0] nxt_rdy;
    logic [31:0] n_acc;
    logic [RETIRE_WIDTH-1:0] vp1;

    // Ready only when a full-width group of stores is guaranteed to fit.
    assign ret.ready = (SQ_DEPTH - int'(sq_count)) >= RETIRE_WIDTH;

    always_comb begin
        nxt_free = '0;
        nxt_rdy  = '0;
        n_acc    = '0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            lane_acc[k]       = ret.valid[k] && ret.ready;
            is_store[k]       = ret.entry[k].rd_opcode == OPC_STORE;
            push[k]           = lane_acc[k] && is_store[k];
            push_data[k].addr = ret.entry[k].rd_value[MEM_AW-1:0];
            push_data[k].data = ret.entry[k].rs1_value;
            n_acc             = n_acc + 32'(lane_acc[k]);
            if (lane_acc[k] && !is_store[k]) begin
                nxt_free[ret.entry[k].old_d_reg]  = 1'b1;
                nxt_rdy[ret.entry[k].curr_d_reg]  = 1'b1;
            end
        end
    end

    store_queue #(
        .DEPTH (SQ_DEPTH),
        .WIDTH (RETIRE_WIDTH)
    ) u_sq (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (!sq_empty),
        .head      (head),
        .count     (sq_count),
        .empty     (sq_empty)
    );

    // Lanes are walked oldest first so the youngest writer wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            register_file <= '0;
        end else begin
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                if (lane_acc[k] && !is_store[k])
                    register_file[ret.entry[k].curr_d_reg] <= ret.entry[k].rd_value;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memory <= '0;
        end else if (!sq_empty) begin
            memory[head.addr] <= head.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            free_regs     <= '0;
            reg_ready_o   <= '0;
            retired_count <= '0;
        end else begin
            free_regs     <= nxt_free;
            reg_ready_o   <= nxt_rdy;
            retired_count <= retired_count + n_acc;
        end
    end

    assign vp1 = ret.valid + RETIRE_WIDTH'(1);

    a_contig: assert property (@(posedge clk) disable iff (reset)
        (vp1 & ret.valid) == '0);

endmodule

// File: tb/tb_retire_writeback.sv
// Directed bench for retire_writeback: vector table plus store/backpressure/reset sequences.
module tb_retire_writeback;
    import my_package::*;

    logic clk;
    logic reset;
    logic [63:0] free_regs;
    logic [63:0] reg_ready_o;
    logic [63:0][31:0] register_file;
    logic [63:0][31:0] memory;
    logic [3:0] sq_count;
    logic sq_empty;
    logic [31:0] retired_count;

    int ncmp = 0;
    int nerr = 0;

    localparam logic [6:0] OPC_ALU = 7'b0110011;

    retire_if #(.WIDTH(2)) rif ();

    retire_writeback dut (
        .clk           (clk),
        .reset         (reset),
        .ret           (rif),
        .free_regs     (free_regs),
        .reg_ready_o   (reg_ready_o),
        .register_file (register_file),
        .memory        (memory),
        .sq_count      (sq_count),
        .sq_empty      (sq_empty),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        rob_entry    e0;
        rob_entry    e1;
        logic [63:0] exp_rdy;
        logic [63:0] exp_free;
        int          r1;
        logic [31:0] v1;
        int          r2;
        logic [31:0] v2;
        logic [31:0] exp_cnt;
        logic [3:0]  exp_sq;
    } vec_t;

    vec_t vecs [5];

    function automatic rob_entry mk(input logic [6:0] opc, input int curr,
                                    input int old, input logic [31:0] rdv,
                                    input logic [31:0] rs1);
        rob_entry e;
        e.rd_opcode  = opc;
        e.curr_d_reg = 6'(curr);
        e.old_d_reg  = 6'(old);
        e.rd_value   = rdv;
        e.rs1_value  = rs1;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rif.valid = 2'b00;
        rif.entry[0] = '0;
        rif.entry[1] = '0;
    endtask

    initial begin
        int mcount;
        int sent;
        bit exp_rdy;
        bit all_zero;

        vecs[0] = '{2'b11, mk(OPC_ALU, 5, 12, 32'h11, 0), mk(OPC_ALU, 6, 13, 32'h22, 0),
                    64'h60, 64'h3000, 5, 32'h11, 6, 32'h22, 32'd2, 4'd0};
        vecs[1] = '{2'b11, mk(OPC_ALU, 9, 20, 32'hA, 0), mk(OPC_ALU, 9, 21, 32'hB, 0),
                    64'h200, 64'h30_0000, 9, 32'hB, 5, 32'h11, 32'd4, 4'd0};
        vecs[2] = '{2'b01, mk(OPC_ALU, 30, 31, 32'hDEADBEEF, 0), mk(OPC_ALU, 40, 41, 32'h5, 0),
                    64'h4000_0000, 64'h8000_0000, 30, 32'hDEADBEEF, 40, 32'h0, 32'd5, 4'd0};
        vecs[3] = '{2'b11, mk(OPC_ALU, 7, 8, 32'h77, 0), mk(OPC_STORE, 50, 51, 32'd10, 32'h55),
                    64'h80, 64'h100, 7, 32'h77, 50, 32'h0, 32'd7, 4'd1};
        vecs[4] = '{2'b00, mk(OPC_ALU, 1, 2, 32'h99, 0), mk(OPC_ALU, 3, 4, 32'h98, 0),
                    64'h0, 64'h0, 1, 32'h0, 3, 32'h0, 32'd7, 4'd0};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;

        all_zero = (register_file == '0) && (memory == '0);
        chk("reset_arrays_zero", 64'(all_zero), 64'd1);
        chk("reset_free", free_regs, 64'h0);
        chk("reset_rdy", reg_ready_o, 64'h0);
        chk("reset_sq_empty", 64'(sq_empty), 64'd1);
        chk("reset_ready", 64'(rif.ready), 64'd1);
        chk("reset_cnt", 64'(retired_count), 64'd0);

        for (int i = 0; i < 5; i++) begin
            rif.valid = vecs[i].valid;
            rif.entry[0] = vecs[i].e0;
            rif.entry[1] = vecs[i].e1;
            step();
            idle_inputs();
            chk($sformatf("v%0d_rdy_mask", i), reg_ready_o, vecs[i].exp_rdy);
            chk($sformatf("v%0d_free_mask", i), free_regs, vecs[i].exp_free);
            chk($sformatf("v%0d_rf_a", i), 64'(register_file[vecs[i].r1]), 64'(vecs[i].v1));
            chk($sformatf("v%0d_rf_b", i), 64'(register_file[vecs[i].r2]), 64'(vecs[i].v2));
            chk($sformatf("v%0d_cnt", i), 64'(retired_count), 64'(vecs[i].exp_cnt));
            chk($sformatf("v%0d_sq", i), 64'(sq_count), 64'(vecs[i].exp_sq));
            step();
            chk($sformatf("v%0d_rdy_clear", i), reg_ready_o, 64'h0);
            chk($sformatf("v%0d_free_clear", i), free_regs, 64'h0);
        end
        chk("mixed_store_mem", 64'(memory[10]), 64'h55);

        // Two stores to one address drain in program order.
        rif.valid = 2'b11;
        rif.entry[0] = mk(OPC_STORE, 1, 2, 32'd3, 32'hAA);
        rif.entry[1] = mk(OPC_STORE, 3, 4, 32'd3, 32'hBB);
        step();
        idle_inputs();
        chk("st_count_after_accept", 64'(sq_count), 64'd2);
        chk("st_mem_not_yet", 64'(memory[3]), 64'h0);
        chk("st_no_rdy_mask", reg_ready_o, 64'h0);
        chk("st_no_free_mask", free_regs, 64'h0);
        step();
        chk("st_mem_first", 64'(memory[3]), 64'hAA);
        chk("st_count_one", 64'(sq_count), 64'd1);
        step();
        chk("st_mem_second", 64'(memory[3]), 64'hBB);
        chk("st_empty", 64'(sq_empty), 64'd1);
        chk("st_cnt", 64'(retired_count), 64'd9);

        // Backpressure: stream two stores per cycle, hold while not ready.
        mcount = 0;
        sent = 0;
        for (int cyc = 0; cyc < 100 && sent < 8; cyc++) begin
            rif.valid = 2'b11;
            rif.entry[0] = mk(OPC_STORE, 0, 0, 32'(20 + 2 * sent), 32'(32'h100 + 2 * sent));
            rif.entry[1] = mk(OPC_STORE, 0, 0, 32'(21 + 2 * sent), 32'(32'h101 + 2 * sent));
            exp_rdy = (8 - mcount) >= 2;
            chk($sformatf("bp_ready_c%0d", cyc), 64'(rif.ready), 64'(exp_rdy));
            step();
            mcount = mcount + (exp_rdy ? 2 : 0) - (mcount > 0 ? 1 : 0);
            if (exp_rdy) sent++;
            chk($sformatf("bp_count_c%0d", cyc), 64'(sq_count), 64'(mcount));
        end
        idle_inputs();
        chk("bp_sent", 64'(sent), 64'd8);
        for (int w = 0; w < 40 && !sq_empty; w++) step();
        chk("bp_drained", 64'(sq_empty), 64'd1);
        for (int i = 0; i < 16; i++)
            chk($sformatf("bp_mem_%0d", 20 + i), 64'(memory[20 + i]), 64'(32'h100 + i));
        chk("bp_cnt", 64'(retired_count), 64'd25);

        // Async reset while four stores are still queued.
        for (int p = 0; p < 3; p++) begin
            rif.valid = 2'b11;
            rif.entry[0] = mk(OPC_STORE, 0, 0, 32'(40 + 2 * p), 32'(32'h200 + 2 * p));
            rif.entry[1] = mk(OPC_STORE, 0, 0, 32'(41 + 2 * p), 32'(32'h201 + 2 * p));
            step();
        end
        idle_inputs();
        chk("rst_pre_count", 64'(sq_count), 64'd4);
        chk("rst_pre_mem", 64'(memory[40]), 64'h200);
        #1 reset = 1'b1;
        #1;
        chk("rst_count_now", 64'(sq_count), 64'd0);
        chk("rst_empty_now", 64'(sq_empty), 64'd1);
        chk("rst_mem_now", 64'(memory[40]), 64'h0);
        chk("rst_rf_now", 64'(register_file[5]), 64'h0);
        chk("rst_cnt_now", 64'(retired_count), 64'd0);
        step();
        #2 reset = 1'b0;
        repeat (6) step();
        all_zero = (memory == '0);
        chk("rst_no_late_writes", 64'(all_zero), 64'd1);
        chk("rst_still_empty", 64'(sq_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/retire_writeback.md
Name: retire_writeback

Overview:
- Parametrised successor to the two-wide retire/writeback stage.
- Accepts up to RETIRE_WIDTH retiring ROB entries per cycle under a valid/ready handshake.
- Commits register results to the physical register file and emits one-cycle free/ready masks to rename and issue.
- Stores are not written to memory directly: they go through an in-order store queue that drains one store per cycle into data memory and applies backpressure to the ROB when full.

Parameters:
- RETIRE_WIDTH, 2, maximum retiring entries accepted per cycle (1..4)
- NUM_PREGS, 64, physical register count; mask width and register file depth
- MEM_DEPTH, 64, data memory words; address uses low $clog2(MEM_DEPTH) bits of rd_value
- SQ_DEPTH, 8, store queue entries (power of two, >= RETIRE_WIDTH)
- DATA_W, 32, register/memory word width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- ret_valid  in  RETIRE_WIDTH  per-lane retire valid; lanes contiguous from lane 0 (oldest)
- ret_entry  in  rob_entry[RETIRE_WIDTH]  retiring entries; lane 0 oldest
- ret_ready  out  1  stage accepts all asserted lanes this cycle
- free_regs  out  NUM_PREGS  one-cycle pulse mask of freed old destination registers
- reg_ready_o  out  NUM_PREGS  one-cycle pulse mask of committed current destination registers
- register_file  out  DATA_W x NUM_PREGS  architectural-visible physical register file
- memory  out  DATA_W x MEM_DEPTH  data memory
- sq_count  out  $clog2(SQ_DEPTH)+1  store queue occupancy
- sq_empty  out  1  store queue empty (drain complete)
- retired_count  out  32  total accepted retirements

Behaviour:
- Reset (async, any time, including mid-drain or mid-handshake):
  - register_file and memory all 0.
  - Store queue emptied: pointers 0, sq_count=0, sq_empty=1.
  - free_regs=0, reg_ready_o=0, retired_count=0.
  - In-flight stores are discarded.
- Handshake:
  - ret_ready = (SQ_DEPTH - sq_count) >= RETIRE_WIDTH. This is combinational from registered count only; it does not depend on ret_valid.
  - A lane is accepted when ret_valid[k] and ret_ready are both high at the edge.
  - If ret_ready is low, nothing is accepted and no state changes except the drain. Upstream holds its entries.
  - Non-contiguous ret_valid is illegal; it is flagged by an assertion.
- Store lane (rd_opcode == 7'b0100011):
  - Push {addr=rd_value[low bits], data=rs1_value} into the store queue, in lane order.
  - No register write, no mask bits.
- Other lane:
  - register_file[curr_d_reg] <= rd_value.
  - free_regs bit old_d_reg and reg_ready_o bit curr_d_reg set for the next cycle.
- Masks:
  - Registered; cleared to 0 every cycle without an accepted non-store lane.
  - Latency: data is visible in register_file, and masks pulse, in the cycle after the acceptance edge.
- Same-cycle conflicts:
  - Two lanes with the same curr_d_reg: the higher (younger) lane's value is written. Mask bits are OR-ed.
- Store queue drain:
  - When not empty, the head is written to memory[addr] each edge and popped.
  - A store accepted at edge T is written at the earliest at edge T+1.
  - Push and pop in the same cycle are allowed. Count changes by (pushes - 1).
  - Multiple pushes to the same address drain in program order, so the last one wins.
  - Pointers wrap modulo SQ_DEPTH.
- retired_count += popcount of accepted lanes (stores included); wraps at 2^32.
- No flush input: retirement is non-speculative.

Decomposition:
- my_package holds:
  - the existing rob_entry typedef;
  - OPC_STORE = 7'b0100011;
  - sq_entry typedef {addr, data}.
- Sub-module store_queue:
  - parametrised FIFO with RETIRE_WIDTH-wide push and single pop;
  - outputs count/empty/head.
- retire_writeback instantiates store_queue and holds the register file, memory, masks and counter.

Test Plan:
- Reset then idle:
  - register_file/memory all 0, masks 0, sq_empty=1, ret_ready=1, retired_count=0.
- Two ALU retires in one cycle:
  - lane0 {curr=5, old=12, rd_value=0x11}, lane1 {curr=6, old=13, rd_value=0x22}.
  - Next cycle: rf[5]=0x11, rf[6]=0x22, reg_ready_o has bits 5,6 set, free_regs has bits 12,13 set.
  - Cycle after: masks 0. retired_count=2.
- Same-destination conflict:
  - lane0 and lane1 both curr=9, values 0xA and 0xB.
  - rf[9]=0xB; reg_ready_o has only bit 9 set.
- Store ordering:
  - lane0 store {rd_value=3, rs1=0xAA}, lane1 store {rd_value=3, rs1=0xBB}.
  - sq_count=2 after accept; memory[3]=0xAA after the first drain, 0xBB after the second; then sq_empty=1.
- Backpressure (SQ_DEPTH=8, RETIRE_WIDTH=2):
  - Stream 2 stores/cycle.
  - ret_ready drops when sq_count=7; valid is held; it rises once the count drains to 6.
  - No store lost or duplicated.
- Async reset mid-drain:
  - Assert reset with sq_count=4.
  - sq_count=0 immediately; memory 0; no further memory writes after deassert.
